// File: rtl/mmio_data_memory.sv
// Data RAM plus memory-mapped output, synchronised input and edge-status ports behind one
// decoder; a mode FSM hands the bus between CPU and programmer with a one-cycle guard.
module mmio_data_memory #(
  parameter int          RAM_WORDS = 64,
  parameter int          N_OPORT   = 4,
  parameter int          N_IPORT   = 4,
  parameter logic [31:0] IO_BASE   = 32'hFFFF_FF00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  prg_mode,
  input  logic                  we,
  input  logic [31:0]           addr,
  input  logic [31:0]           wd,
  output logic [31:0]           rd,
  input  logic                  prg_we,
  input  logic [31:0]           prg_addr,
  input  logic [31:0]           prg_wd,
  output logic [31:0]           prg_rd,
  output logic                  prg_active,
  output logic [32*N_OPORT-1:0] oport,
  input  logic [32*N_IPORT-1:0] iport,
  output logic                  irq
);

  localparam int AW = $clog2(RAM_WORDS);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    SW2P = 2'd1,
    PRG  = 2'd2,
    SW2R = 2'd3
  } mode_t;

  mode_t          state_r;
  mode_t          state_s;

  logic [31:0]    mem_r   [RAM_WORDS];
  logic [31:0]    out_r   [N_OPORT];
  logic [31:0]    sync1_r [N_IPORT];
  logic [31:0]    sync2_r [N_IPORT];
  logic [31:0]    prev_r  [N_IPORT];
  logic [31:0]    edge_r  [N_IPORT];
  logic           edge_en_r;

  logic [31:0]    bus_addr_s;
  logic [31:0]    bus_wd_s;
  logic           bus_we_s;
  logic           io_s;
  logic [1:0]     region_s;
  logic [3:0]     idx_s;
  logic [AW-1:0]  ram_idx_s;
  logic           ram_we_s;
  logic [31:0]    read_s;
  logic [N_OPORT-1:0] out_we_s;
  logic [31:0]    clr_s   [N_IPORT];
  logic           irq_s;

  // Mode state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= RUN;
    end else begin
      state_r <= state_s;
    end
  end

  // Mode next-state: guard states always last exactly one cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      RUN:     state_s = prg_mode ? SW2P : RUN;
      SW2P:    state_s = PRG;
      PRG:     state_s = prg_mode ? PRG : SW2R;
      SW2R:    state_s = RUN;
      default: state_s = RUN;
    endcase
  end

  // Bus owner mux; in guard states nothing reaches the decoder.
  always_comb begin
    bus_addr_s = 32'd0;
    bus_wd_s   = 32'd0;
    bus_we_s   = 1'b0;
    case (state_r)
      RUN: begin
        bus_addr_s = addr;
        bus_wd_s   = wd;
        bus_we_s   = we;
      end
      PRG: begin
        bus_addr_s = prg_addr;
        bus_wd_s   = prg_wd;
        bus_we_s   = prg_we;
      end
      default: begin
        bus_addr_s = 32'd0;
        bus_wd_s   = 32'd0;
        bus_we_s   = 1'b0;
      end
    endcase
  end

  assign io_s      = (bus_addr_s & ~32'h0000_00FF) == IO_BASE;
  assign region_s  = bus_addr_s[7:6];
  assign idx_s     = bus_addr_s[5:2];
  assign ram_idx_s = bus_addr_s[AW+1:2];
  assign ram_we_s  = bus_we_s && !io_s;

  // Read mux over RAM and the I/O window; unmapped offsets read zero.
  always_comb begin
    read_s = 32'd0;
    if (!io_s) begin
      read_s = mem_r[ram_idx_s];
    end else begin
      case (region_s)
        2'b00: for (int i = 0; i < N_OPORT; i++)
                 read_s = read_s | ((int'(idx_s) == i) ? out_r[i] : 32'd0);
        2'b01: for (int i = 0; i < N_IPORT; i++)
                 read_s = read_s | ((int'(idx_s) == i) ? sync2_r[i] : 32'd0);
        2'b10: for (int i = 0; i < N_IPORT; i++)
                 read_s = read_s | ((int'(idx_s) == i) ? edge_r[i] : 32'd0);
        2'b11:   read_s = (idx_s == 4'd0) ? {16'h0000, 8'(N_IPORT), 8'(N_OPORT)} : 32'd0;
        default: read_s = 32'd0;
      endcase
    end
  end

  // Per-port write strobes and W1C masks.
  always_comb begin
    for (int i = 0; i < N_OPORT; i++) begin
      out_we_s[i] = bus_we_s && io_s && (region_s == 2'b00) && (int'(idx_s) == i);
    end
    for (int i = 0; i < N_IPORT; i++) begin
      clr_s[i] = (bus_we_s && io_s && (region_s == 2'b10) && (int'(idx_s) == i)) ? bus_wd_s : 32'd0;
    end
  end

  // RAM write port; contents survive reset but reset still blocks the write.
  always_ff @(posedge clk) begin
    if (!reset && ram_we_s) begin
      mem_r[ram_idx_s] <= bus_wd_s;
    end
  end

  // Output port registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_OPORT; i++) out_r[i] <= 32'd0;
    end else begin
      for (int i = 0; i < N_OPORT; i++) begin
        if (out_we_s[i]) out_r[i] <= bus_wd_s;
      end
    end
  end

  // Input synchronisers and rising-edge capture; a new set beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_en_r <= 1'b0;
      for (int i = 0; i < N_IPORT; i++) begin
        sync1_r[i] <= 32'd0;
        sync2_r[i] <= 32'd0;
        prev_r[i]  <= 32'd0;
        edge_r[i]  <= 32'd0;
      end
    end else begin
      edge_en_r <= 1'b1;
      for (int i = 0; i < N_IPORT; i++) begin
        sync1_r[i] <= iport[32*i +: 32];
        sync2_r[i] <= sync1_r[i];
        prev_r[i]  <= sync2_r[i];
        edge_r[i]  <= (edge_r[i] & ~clr_s[i]) |
                      (edge_en_r ? (sync2_r[i] & ~prev_r[i]) : 32'd0);
      end
    end
  end

  // Interrupt is the OR of every edge-status bit.
  always_comb begin
    irq_s = 1'b0;
    for (int i = 0; i < N_IPORT; i++) irq_s = irq_s | (|edge_r[i]);
  end

  for (genvar g = 0; g < N_OPORT; g++) begin : g_oport
    assign oport[32*g +: 32] = out_r[g];
  end

  assign irq        = irq_s;
  assign prg_active = (state_r == PRG);
  assign rd         = (state_r == RUN) ? read_s : 32'd0;
  assign prg_rd     = (state_r == PRG) ? read_s : 32'd0;

endmodule

// File: tb/tb_mmio_data_memory.sv
// Randomized bench for mmio_data_memory against a behavioural model of bus ownership,
// RAM, port registers, input history and edge status.
module tb_mmio_data_memory;

  localparam int          RW = 64;
  localparam int          NO = 4;
  localparam int          NI = 4;
  localparam logic [31:0] IO_BASE = 32'hFFFF_FF00;

  logic            clk = 1'b0;
  logic            reset, prg_mode, we, prg_we;
  logic [31:0]     addr, wd, prg_addr, prg_wd;
  logic [31:0]     rd, prg_rd;
  logic            prg_active, irq;
  logic [32*NO-1:0] oport;
  logic [32*NI-1:0] iport;

  int tests_run = 0;
  int tests_failed = 0;

  mmio_data_memory #(.RAM_WORDS(RW), .N_OPORT(NO), .N_IPORT(NI), .IO_BASE(IO_BASE)) dut (
    .clk(clk), .reset(reset), .prg_mode(prg_mode), .we(we), .addr(addr), .wd(wd), .rd(rd),
    .prg_we(prg_we), .prg_addr(prg_addr), .prg_wd(prg_wd), .prg_rd(prg_rd),
    .prg_active(prg_active), .oport(oport), .iport(iport), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0]      m_mem   [RW];
  bit               m_known [RW];
  logic [31:0]      m_out   [NO];
  logic [31:0]      m_edge  [NI];
  logic [32*NI-1:0] hist[$];   // [0] previous IN, [1] current IN, [2] first-stage sample
  bit               m_init = 1'b0;
  bit               m_owner_prg, m_guard;
  int               m_since;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_io(input logic [31:0] a);
    return a[31:8] == IO_BASE[31:8];
  endfunction

  function automatic bit model_known(input logic [31:0] a);
    return is_io(a) || m_known[a[7:2]];
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int off;
    off = int'(a[7:0]);
    if (!is_io(a)) return m_mem[a[7:2]];
    if (off < 4*NO) return m_out[off/4];
    if (off >= 64 && off < 64 + 4*NI) return hist[1][32*((off-64)/4) +: 32];
    if (off >= 128 && off < 128 + 4*NI) return m_edge[(off-128)/4];
    if (off >= 192 && off < 196) return {16'h0000, 8'(NI), 8'(NO)};
    return 32'd0;
  endfunction

  task automatic model_step();
    bit w;
    logic [31:0] wa, wdat, clr;
    logic [32*NI-1:0] cur, prv;
    int off;
    if (reset) begin
      m_init = 1'b1; m_owner_prg = 1'b0; m_guard = 1'b0; m_since = 0;
      for (int p = 0; p < NO; p++) m_out[p] = 32'd0;
      for (int p = 0; p < NI; p++) m_edge[p] = 32'd0;
      hist = {'0, '0, '0};
      return;
    end
    if (!m_init) return;
    w = 1'b0; wa = 32'd0; wdat = 32'd0;
    if (!m_guard) begin
      if (m_owner_prg) begin w = prg_we; wa = prg_addr; wdat = prg_wd; end
      else             begin w = we;     wa = addr;     wdat = wd;     end
    end
    off = int'(wa[7:0]);
    cur = hist[1];
    prv = hist[0];
    for (int p = 0; p < NI; p++) begin
      clr = (w && is_io(wa) && off >= 128 && off < 128 + 4*NI && (off-128)/4 == p) ? wdat : 32'd0;
      m_edge[p] = (m_edge[p] & ~clr) |
                  ((m_since >= 1) ? (cur[32*p +: 32] & ~prv[32*p +: 32]) : 32'd0);
    end
    if (w) begin
      if (!is_io(wa)) begin
        m_mem[wa[7:2]] = wdat;
        m_known[wa[7:2]] = 1'b1;
      end else if (off < 4*NO) begin
        m_out[off/4] = wdat;
      end
    end
    hist.push_back(iport);
    void'(hist.pop_front());
    if (m_guard) m_guard = 1'b0;
    else if (prg_mode != m_owner_prg) begin
      m_owner_prg = prg_mode;
      m_guard = 1'b1;
    end
    m_since++;
  endtask

  task automatic check_outputs();
    logic [31:0] any_edge;
    if (!m_init) return;
    if (!m_guard && !m_owner_prg) begin
      if (model_known(addr)) check_eq("rd", rd, model_read(addr));
    end else begin
      check_eq("rd_idle", rd, 32'd0);
    end
    if (!m_guard && m_owner_prg) begin
      if (model_known(prg_addr)) check_eq("prg_rd", prg_rd, model_read(prg_addr));
    end else begin
      check_eq("prg_rd_idle", prg_rd, 32'd0);
    end
    check_eq("prg_active", {31'd0, prg_active}, {31'd0, m_owner_prg && !m_guard});
    any_edge = 32'd0;
    for (int p = 0; p < NI; p++) any_edge = any_edge | m_edge[p];
    check_eq("irq", {31'd0, irq}, {31'd0, |any_edge});
    for (int p = 0; p < NO; p++) check_eq("oport", oport[32*p +: 32], m_out[p]);
  endtask

  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return $urandom & 32'h0000_00FF;
      1:       return $urandom;
      default: return IO_BASE | 32'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    reset = 1'b1; prg_mode = 1'b0; we = 1'b0; prg_we = 1'b0;
    addr = 32'd0; wd = 32'd0; prg_addr = 32'd0; prg_wd = 32'd0; iport = '0;
    cycle(); cycle();
    reset = 1'b0;
    #1;
    check_eq("rst_prg_active", {31'd0, prg_active}, 32'd0);
    check_eq("rst_irq", {31'd0, irq}, 32'd0);
    check_eq("rst_oport1", oport[63:32], 32'd0);

    // CPU write then read back
    we = 1'b1; addr = 32'h10; wd = 32'hDEAD_BEEF; cycle();
    we = 1'b0; #1;
    check_eq("t1_rd", rd, 32'hDEAD_BEEF);
    check_eq("t1_prg_rd", prg_rd, 32'd0);
    cycle();

    // RAM aliasing modulo depth
    we = 1'b1; addr = 32'h000; wd = 32'h11; cycle();
    we = 1'b0; addr = 32'h100; #1;
    check_eq("t2_alias", rd, 32'h11);
    cycle();

    // Mode handover with dropped guard-cycle write
    we = 1'b1; addr = 32'h20; wd = 32'h1234; cycle();
    we = 1'b0; prg_mode = 1'b1; cycle();
    prg_we = 1'b1; prg_addr = 32'h20; prg_wd = 32'h77; #1;
    check_eq("t3_guard_active", {31'd0, prg_active}, 32'd0);
    cycle();
    prg_we = 1'b0; #1;
    check_eq("t3_prg_active", {31'd0, prg_active}, 32'd1);
    check_eq("t3_guard_drop", prg_rd, 32'h1234);
    prg_we = 1'b1; prg_wd = 32'h55; we = 1'b1; wd = 32'h99; cycle();
    prg_we = 1'b0; we = 1'b0; #1;
    check_eq("t3_prg_rd", prg_rd, 32'h55);
    check_eq("t3_rd_zero", rd, 32'd0);
    cycle();
    prg_mode = 1'b0; cycle();
    #1;
    check_eq("t3_sw2r_active", {31'd0, prg_active}, 32'd0);
    check_eq("t3_sw2r_rd", rd, 32'd0);
    cycle();
    #1;
    check_eq("t3_run_rd", rd, 32'h55);

    // Output port, input sync latency, edge capture and W1C
    we = 1'b1; addr = IO_BASE + 32'h04; wd = 32'hA5; cycle();
    we = 1'b0; addr = IO_BASE + 32'h40; iport[31:0] = 32'h3; #1;
    check_eq("t4_oport1", oport[63:32], 32'hA5);
    cycle();
    #1;
    check_eq("t4_in_early", rd, 32'd0);
    cycle();
    #1;
    check_eq("t4_in0", rd, 32'h3);
    check_eq("t4_irq_early", {31'd0, irq}, 32'd0);
    cycle();
    addr = IO_BASE + 32'h80; #1;
    check_eq("t4_edge0", rd, 32'h3);
    check_eq("t4_irq", {31'd0, irq}, 32'd1);
    we = 1'b1; wd = 32'h1; cycle();
    we = 1'b0; #1;
    check_eq("t4_w1c", rd, 32'h2);
    addr = IO_BASE + 32'hC0; #1;
    check_eq("t4_info", rd, 32'h0000_0404);
    addr = IO_BASE + 32'h50; #1;
    check_eq("t4_unmapped", rd, 32'd0);
    addr = IO_BASE + 32'h80;

    // Set beats clear in the same cycle
    iport[31:0] = 32'h2; cycle(); cycle(); cycle();
    iport[31:0] = 32'h3; cycle(); cycle();
    we = 1'b1; wd = 32'h1; cycle();
    we = 1'b0; #1;
    check_eq("t5_race", rd, 32'h3);

    // Reset while programmer owns the bus and writes
    prg_mode = 1'b1; cycle(); cycle();
    reset = 1'b1; prg_we = 1'b1; prg_addr = 32'h20; prg_wd = 32'hBAD; cycle();
    reset = 1'b0; prg_we = 1'b0; prg_mode = 1'b0; addr = 32'h20; #1;
    check_eq("t6_active", {31'd0, prg_active}, 32'd0);
    check_eq("t6_oport1", oport[63:32], 32'd0);
    check_eq("t6_irq", {31'd0, irq}, 32'd0);
    check_eq("t6_ram", rd, 32'h55);
    cycle();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int p;
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 15) == 0) prg_mode = ~prg_mode;
      we = 1'($urandom_range(0, 1));
      prg_we = 1'($urandom_range(0, 1));
      addr = rand_addr(); wd = $urandom;
      prg_addr = rand_addr(); prg_wd = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        p = $urandom_range(0, NI-1);
        iport[32*p +: 32] = $urandom;
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
